// File: rtl/clock_pkg.sv
// Shared definitions for the minutes/seconds clock slice.
// Mode encoding, digit limits and BCD 00..59 helpers.
package clock_pkg;

    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] SET = 1'b1;

    localparam logic [3:0] DIGIT1_MAX = 4'd9;
    localparam logic [2:0] DIGIT2_MAX = 3'd5;

    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] units;
    } bcd60_t;

    function automatic logic bcd60_last(input bcd60_t v);
        return (v.tens == DIGIT2_MAX) && (v.units == DIGIT1_MAX);
    endfunction

    // Out-of-range codes fold back to zero rather than counting on.
    function automatic bcd60_t bcd60_inc(input bcd60_t v);
        bcd60_t r;
        r = v;
        if (v.units >= DIGIT1_MAX) begin
            r.units = 4'd0;
            if (v.tens >= DIGIT2_MAX)
                r.tens = 3'd0;
            else
                r.tens = v.tens + 3'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1, tick on the last count.
// clear holds the count at zero.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/min_sec_counter.sv
// MM:SS counter with run/set modes; hour_carry clocks the hours stage.
// Seconds and minutes are held as BCD digit pairs.
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [3:0] sec_digit1,
    output logic [2:0] sec_digit2,
    output logic [3:0] min_digit1,
    output logic [2:0] min_digit2,
    output logic       hour_carry
);

    logic [0:0] state;
    logic       in_set;
    logic       tick;
    logic       run_tick;
    logic       inc_min_q;
    logic       inc_hour_q;
    logic       min_rise;
    logic       hour_rise;
    logic       wrap;
    bcd60_t     sec_q;
    bcd60_t     min_q;

    assign in_set = (state == SET);

    tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(in_set),
        .tick (tick)
    );

    assign run_tick  = tick && !in_set;
    assign min_rise  = in_set && inc_min && !inc_min_q;
    assign hour_rise = in_set && inc_hour && !inc_hour_q;
    assign wrap      = run_tick && bcd60_last(sec_q)
                       && bcd60_last(min_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:     state <= set_mode ? SET : RUN;
                SET:     state <= set_mode ? SET : RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
        end else begin
            inc_min_q  <= inc_min;
            inc_hour_q <= inc_hour;
        end
    end

    // Leaving SET restarts the seconds together with the prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q <= '0;
            min_q <= '0;
        end else if (in_set) begin
            if (!set_mode)
                sec_q <= '0;
            if (min_rise)
                min_q <= bcd60_inc(min_q);
        end else if (run_tick) begin
            sec_q <= bcd60_inc(sec_q);
            if (bcd60_last(sec_q))
                min_q <= bcd60_inc(min_q);
        end
    end

    // The self-mask keeps a RUN wrap and a SET hour step from pairing up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hour_carry <= 1'b0;
        else
            hour_carry <= (wrap || hour_rise) && !hour_carry;
    end

    assign sec_digit1 = sec_q.units;
    assign sec_digit2 = sec_q.tens;
    assign min_digit1 = min_q.units;
    assign min_digit2 = min_q.tens;

endmodule

// File: tb/tb_min_sec_counter.sv
// Scoreboard bench for min_sec_counter, CLK_HZ = 4.
// Model tracks total seconds as an integer.
module tb_min_sec_counter;

    localparam int CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_mode = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic [3:0] sec_digit1;
    logic [2:0] sec_digit2;
    logic [3:0] min_digit1;
    logic [2:0] min_digit2;
    logic       hour_carry;

    min_sec_counter #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .set_mode  (set_mode),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .sec_digit1(sec_digit1),
        .sec_digit2(sec_digit2),
        .min_digit1(min_digit1),
        .min_digit2(min_digit2),
        .hour_carry(hour_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mm;
        int ss;
        bit hc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   hc_seen = 0;

    int   m_secs = 0;
    int   m_pre = 0;
    bit   m_set = 0;
    bit   m_pim = 0;
    bit   m_pih = 0;
    bit   m_hc = 0;

    function automatic int dut_min();
        return int'(min_digit2) * 10 + int'(min_digit1);
    endfunction

    function automatic int dut_sec();
        return int'(sec_digit2) * 10 + int'(sec_digit1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_secs = 0;
        m_pre = 0;
        m_set = 0;
        m_pim = 0;
        m_pih = 0;
        m_hc = 0;
    endtask

    task automatic model_step(input bit sm, input bit im, input bit ih);
        int   mm;
        int   ss;
        bit   hc;
        exp_t e;
        mm = m_secs / 60;
        ss = m_secs % 60;
        hc = 0;
        if (m_set) begin
            if (!sm) ss = 0;
            if (im && !m_pim) mm = (mm + 1) % 60;
            if (ih && !m_pih) hc = 1;
            m_secs = mm * 60 + ss;
            m_pre = 0;
        end else if (m_pre == CLK_HZ - 1) begin
            m_pre = 0;
            m_secs = (m_secs + 1) % 3600;
            if (m_secs == 0) hc = 1;
        end else begin
            m_pre++;
        end
        if (m_hc) hc = 0;
        m_hc = hc;
        m_set = sm;
        m_pim = im;
        m_pih = ih;
        e.mm = m_secs / 60;
        e.ss = m_secs % 60;
        e.hc = hc;
        q.push_back(e);
    endtask

    // Called just after a falling edge; returns after the next one.
    task automatic cycle(input bit sm, input bit im, input bit ih);
        set_mode = sm;
        inc_min  = im;
        inc_hour = ih;
        model_step(sm, im, ih);
        @(negedge clk);
    endtask

    task automatic set_minutes(input int target);
        int n;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        n = 0;
        while (m_secs / 60 != target && n < 70) begin
            cycle(1, 1, 0);
            cycle(1, 0, 0);
            n++;
        end
        check("preset_minutes", m_secs / 60, target);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (hour_carry) hc_seen++;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (dut_min() != e.mm || dut_sec() != e.ss
                || hour_carry !== e.hc) begin
                errors++;
                $display("FAIL cycle_out: got %0d:%0d hc=%0b expected %0d:%0d hc=%0b",
                         dut_min(), dut_sec(), hour_carry,
                         e.mm, e.ss, e.hc);
            end
            checks++;
            if (sec_digit1 > 9 || sec_digit2 > 5
                || min_digit1 > 9 || min_digit2 > 5) begin
                errors++;
                $display("FAIL digit_range: got %0d%0d:%0d%0d required digits in range",
                         min_digit2, min_digit1, sec_digit2, sec_digit1);
            end
        end
    end

    initial begin
        int h0;
        int s0;
        int n;

        #12;
        check("reset_sec", dut_sec(), 0);
        check("reset_min", dut_min(), 0);
        check("reset_hc", int'(hour_carry), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 240; i++) cycle(0, 0, 0);
        check("run240_min1", int'(min_digit1), 1);
        check("run240_min2", int'(min_digit2), 0);
        check("run240_sec", dut_sec(), 0);
        check("run240_hc_count", hc_seen, 0);

        set_minutes(58);
        s0 = dut_sec();
        h0 = hc_seen;
        cycle(1, 1, 0);
        check("incmin_59", dut_min(), 59);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("incmin_00", dut_min(), 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("incmin_01", dut_min(), 1);
        cycle(1, 0, 0);
        check("incmin_sec_held", dut_sec(), s0);
        check("incmin_no_hc", hc_seen - h0, 0);

        set_minutes(10);
        h0 = hc_seen;
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        check("both_min", dut_min(), 11);
        check("both_hc", hc_seen - h0, 1);
        h0 = hc_seen;
        for (int i = 0; i < 10; i++) cycle(1, 0, 1);
        cycle(1, 0, 0);
        check("held_hour_hc", hc_seen - h0, 1);

        set_minutes(59);
        cycle(0, 0, 0);
        n = 0;
        while (m_secs != 59 * 60 + 58 && n < 400) begin
            cycle(0, 0, 0);
            n++;
        end
        check("reach_5958", dut_min() * 60 + dut_sec(), 59 * 60 + 58);
        h0 = hc_seen;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0);
        check("wrap_time", dut_min() * 60 + dut_sec(), 0);
        check("wrap_hc_count", hc_seen - h0, 1);

        n = 0;
        while (m_secs % 60 != 37 && n < 300) begin
            cycle(0, 0, 0);
            n++;
        end
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        s0 = dut_min();
        cycle(0, 0, 0);
        check("exit_sec_clear", dut_sec(), 0);
        check("exit_min_kept", dut_min(), s0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        check("exit_no_early_tick", dut_sec(), 0);
        cycle(0, 0, 0);
        check("exit_first_tick", dut_sec(), 1);

        for (int i = 0; i < 600; i++) begin
            bit sm;
            sm = set_mode;
            if ($urandom_range(0, 24) == 0) sm = !sm;
            cycle(sm, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
        end

        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        check("pulse_before_reset", int'(hour_carry), 1);
        reset = 1'b0;
        #1;
        check("async_hc", int'(hour_carry), 0);
        check("async_digits", dut_min() * 60 + dut_sec(), 0);
        model_reset();
        set_mode = 1'b1;
        inc_min  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1, 1, 0);
        check("release_no_inc", dut_min(), 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("inc_after_release", dut_min(), 1);

        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/min_sec_counter.md
MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clk cycles per second; minimum 2.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; a low level forces reset state immediately.
REQ-004 set_mode  input  1  level; 1 = time-setting mode, 0 = run mode; synchronous to clk.
REQ-005 inc_min  input  1  level (debounced, synchronous); each rising edge adds one minute in set mode.
REQ-006 inc_hour  input  1  level (debounced, synchronous); each rising edge requests one hour step in set mode.
REQ-007 sec_digit1  output  4  seconds units, BCD 0..9.
REQ-008 sec_digit2  output  3  seconds tens, 0..5.
REQ-009 min_digit1  output  4  minutes units, BCD 0..9.
REQ-010 min_digit2  output  3  minutes tens, 0..5.
REQ-011 hour_carry  output  1  registered single-cycle pulse; drives the clock input of the downstream 24-hour counter.

Function
REQ-012 Prescaler shall count 0..CLK_HZ-1 and wrap; a one-cycle tick shall assert on the cycle the count equals CLK_HZ-1.
REQ-013 Mode FSM shall have states RUN and SET; RUN->SET when set_mode=1, SET->RUN when set_mode=0; transitions take one clk.
REQ-014 In RUN, each tick shall advance MM:SS by one second, BCD per digit: digit1 9->0 with carry into digit2; sec_digit2 5->0 with carry into minutes.
REQ-015 In RUN, the tick at 59:59 shall load 00:00 and assert hour_carry for exactly one cycle, the same cycle the outputs show 00:00.
REQ-016 Digits shall only change on a tick in RUN; there is no other increment source in RUN.
REQ-017 In SET, the prescaler shall be held at 0 and seconds digits held.
REQ-018 In SET, a rising edge on inc_min shall add one minute with wrap 59->00 and shall not assert hour_carry.
REQ-019 In SET, a rising edge on inc_hour shall assert hour_carry for one cycle; minutes and seconds unchanged.
REQ-020 inc_min and inc_hour rising edges in the same cycle shall both take effect in that cycle.
REQ-021 Edge detection shall use registered previous values; a level held high yields exactly one increment; edges in RUN shall be ignored and not queued.
REQ-022 On the SET->RUN transition, seconds shall clear to 00 and the prescaler restart at 0; the first tick follows CLK_HZ cycles later.
REQ-023 hour_carry shall never assert on two consecutive cycles and shall be driven directly from a flop (glitch-free).
REQ-024 Digit values outside their ranges shall be unreachable from reset.

Reset
REQ-025 While reset=0: all digits 0, hour_carry 0, prescaler 0, FSM in RUN, edge-detect registers 0.
REQ-026 Reset asserted mid-operation (including during a hour_carry pulse or in SET) shall clear state asynchronously; release resumes in RUN with the first tick CLK_HZ cycles after release.
REQ-027 An input held high across reset release shall not produce an increment.

Structure
REQ-028 Shared package clock_pkg shall hold the mode state encoding (RUN, SET) and digit limit constants (9, 5).
REQ-029 The prescaler shall be a sub-module named tick_gen with parameter CLK_HZ, ports clk, reset, clear, tick.
REQ-030 Seconds/minutes digit logic and mode FSM reside in min_sec_counter.

Verification (CLK_HZ=4)
REQ-031 Reset release, set_mode=0, run 240 cycles -> outputs 01:00 (min_digit1=1, others 0), hour_carry never asserted.
REQ-032 Preload to 59:58 via set mode, then run 8 cycles -> 59:59 then 00:00 with hour_carry high exactly one cycle, coincident with 00:00.
REQ-033 set_mode=1, three inc_min pulses from 58:xx -> 59, 00, 01; hour_carry stays 0; seconds unchanged.
REQ-034 set_mode=1, inc_min and inc_hour rise in same cycle at 10:xx -> minutes 11 and one hour_carry pulse; inc_hour held high 10 cycles -> one pulse only.
REQ-035 Drop set_mode with seconds at 37 -> seconds 00 next cycle; first increment to 00:01 exactly 4 cycles later.
REQ-036 reset asserted asynchronously mid hour_carry pulse -> hour_carry and all digits 0 immediately; inc_min held high across release -> no increment.
